// File: rtl/chimera_clu_pwr_ctrl.sv
// chimera_clu_pwr_ctrl: per-cluster power sequencer ordering clock enable, reset and AXI isolation.
module chimera_clu_pwr_ctrl #(
  parameter int unsigned NumClusters      = 1,
  parameter int unsigned RstHoldCycles    = 4,
  parameter int unsigned ClkSettleCycles  = 2,
  parameter int unsigned IsoTimeoutCycles = 1024
) (
  input  logic                   soc_clk_i,
  input  logic                   rst_ni,
  input  logic [NumClusters-1:0] pwr_req_i,
  input  logic [NumClusters-1:0] isolated_i,
  input  logic [NumClusters-1:0] clr_err_i,
  output logic [NumClusters-1:0] isolate_o,
  output logic [NumClusters-1:0] clu_clk_en_o,
  output logic [NumClusters-1:0] clu_rst_no,
  output logic [NumClusters-1:0] pwr_ack_o,
  output logic [NumClusters-1:0] busy_o,
  output logic [NumClusters-1:0] err_o
);
  localparam int unsigned MaxRs = RstHoldCycles > ClkSettleCycles ? RstHoldCycles : ClkSettleCycles;
  localparam int unsigned MaxCycles = MaxRs > IsoTimeoutCycles ? MaxRs : IsoTimeoutCycles;
  localparam int unsigned CntW = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] RstLoad = CntW'(RstHoldCycles - 1);
  localparam logic [CntW-1:0] SettleLoad = CntW'(ClkSettleCycles - 1);
  localparam logic [CntW-1:0] IsoLoad = CntW'(IsoTimeoutCycles - 1);
  // Encoding is {iso, clk_en, rst_n, ack, busy, tag} so every output is a state register bit.
  typedef enum logic [5:0] {
    OFF        = 6'b100000,
    CLK_ON     = 6'b110010,
    RST_REL    = 6'b111010,
    DEISO      = 6'b011010,
    ON         = 6'b011100,
    ISO_WAIT   = 6'b111011,
    RST_ASSERT = 6'b110011
  } state_e;

  for (genvar c = 0; c < NumClusters; c++) begin : g_clu
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_set;

    always_comb begin
      state_d = state_q;
      case (state_q)
        OFF:        if (pwr_req_i[c]) state_d = CLK_ON;
        CLK_ON:     if (cnt_q == '0) state_d = RST_REL;
        RST_REL:    if (cnt_q == '0) state_d = DEISO;
        DEISO:      if (!isolated_i[c]) state_d = ON;
        ON:         if (!pwr_req_i[c]) state_d = ISO_WAIT;
        ISO_WAIT:   state_d = isolated_i[c] ? RST_ASSERT : pwr_req_i[c] ? DEISO : ISO_WAIT;
        RST_ASSERT: if (cnt_q == '0) state_d = OFF;
        default:    state_d = OFF;
      endcase
      cnt_d = state_d == state_q ? (cnt_q == '0 ? '0 : cnt_q - CntW'(1)) :
              state_d == RST_REL ? SettleLoad :
              state_d == ISO_WAIT ? IsoLoad :
              (state_d == CLK_ON || state_d == RST_ASSERT) ? RstLoad : '0;
      // Flag only the cycle the timeout expires, so a later clear sticks while still waiting.
      err_set = state_d == ISO_WAIT && cnt_d == '0 && (state_q != ISO_WAIT || cnt_q != '0);
    end

    always_ff @(posedge soc_clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= OFF;
        cnt_q   <= '0;
        err_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        err_q   <= err_set | (err_q & ~clr_err_i[c]);
      end
    end

    assign isolate_o[c]    = state_q[5];
    assign clu_clk_en_o[c] = state_q[4];
    assign clu_rst_no[c]   = state_q[3];
    assign pwr_ack_o[c]    = state_q[2];
    assign busy_o[c]       = state_q[1];
    assign err_o[c]        = err_q;
  end
endmodule

// File: tb/tb_chimera_clu_pwr_ctrl.sv
// tb_chimera_clu_pwr_ctrl: table-driven scoreboard bench for the two-cluster power sequencer.
module tb_chimera_clu_pwr_ctrl;
  localparam int N = 2;
  localparam logic [5:0] S_OFF = 6'b100000, S_CKON = 6'b110010, S_RREL = 6'b111010;
  localparam logic [5:0] S_DEISO = 6'b011010, S_ON = 6'b011100, S_IWAIT = 6'b111010;
  localparam logic [5:0] S_RASS = 6'b110010, S_ERR = 6'b000001;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req, iso_in, clr, iso_out, clk_en, rst_no, ack, busy, err;
  int           checks = 0;
  int           errors = 0;

  typedef struct {
    string      name;
    logic [1:0] req, fol, isv, clr;
    int         cyc;
    logic [5:0] e0, e1;
  } vec_t;

  vec_t vecs_a[$];
  vec_t vecs_b[$];
  vec_t sb[$];

  chimera_clu_pwr_ctrl #(
    .NumClusters(N), .RstHoldCycles(4), .ClkSettleCycles(2), .IsoTimeoutCycles(8)
  ) dut (
    .soc_clk_i(clk), .rst_ni(rst_n), .pwr_req_i(req), .isolated_i(iso_in), .clr_err_i(clr),
    .isolate_o(iso_out), .clu_clk_en_o(clk_en), .clu_rst_no(rst_no), .pwr_ack_o(ack),
    .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string n, logic [1:0] r, logic [1:0] f, logic [1:0] s, logic [1:0] cl,
                              int cy, logic [5:0] a, logic [5:0] b);
    vec_t v;
    v.name = n; v.req = r; v.fol = f; v.isv = s; v.clr = cl; v.cyc = cy; v.e0 = a; v.e1 = b;
    return v;
  endfunction

  function automatic logic [5:0] obs(int c);
    return {iso_out[c], clk_en[c], rst_no[c], ack[c], busy[c], err[c]};
  endfunction

  task automatic check_sb();
    vec_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: no expectation queued");
    end else begin
      e = sb.pop_front();
      if ({obs(0), obs(1)} !== {e.e0, e.e1}) begin
        errors++;
        $display("FAIL %s: got c0=%b c1=%b expected c0=%b c1=%b (iso,clk,rst_n,ack,busy,err)",
                 e.name, obs(0), obs(1), e.e0, e.e1);
      end
    end
  endtask

  task automatic inv_check();
    for (int c = 0; c < N; c++) begin
      checks++;
      if ((!clk_en[c] && rst_no[c]) || (!iso_out[c] && !(rst_no[c] && clk_en[c]))) begin
        errors++;
        $display("FAIL order c%0d: iso=%b clk_en=%b rst_n=%b, required rst_n->clk_en and !iso->rst_n&clk_en",
                 c, iso_out[c], clk_en[c], rst_no[c]);
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [N-1:0] prev;
    sb.push_back(v);
    req = v.req;
    clr = v.clr;
    for (int c = 0; c < N; c++) if (!v.fol[c]) iso_in[c] = v.isv[c];
    for (int i = 0; i < v.cyc; i++) begin
      prev = iso_out;
      @(posedge clk);
      #1;
      clr = '0;
      for (int c = 0; c < N; c++) if (v.fol[c]) iso_in[c] = prev[c];
      inv_check();
    end
    @(negedge clk);
    check_sb();
  endtask

  initial begin
    vecs_a.push_back(mk("rst_idle", 2'b00, 2'b00, 2'b11, 2'b00, 3, S_OFF, S_OFF));
    vecs_a.push_back(mk("pu_c1",    2'b01, 2'b01, 2'b11, 2'b00, 1, S_CKON, S_OFF));
    vecs_a.push_back(mk("pu_c4",    2'b01, 2'b01, 2'b11, 2'b00, 3, S_CKON, S_OFF));
    vecs_a.push_back(mk("pu_c5",    2'b01, 2'b01, 2'b11, 2'b00, 1, S_RREL, S_OFF));
    vecs_a.push_back(mk("pu_c6",    2'b01, 2'b01, 2'b11, 2'b00, 1, S_RREL, S_OFF));
    vecs_a.push_back(mk("pu_c7",    2'b01, 2'b01, 2'b11, 2'b00, 1, S_DEISO, S_OFF));
    vecs_a.push_back(mk("pu_c8",    2'b01, 2'b01, 2'b11, 2'b00, 1, S_DEISO, S_OFF));
    vecs_a.push_back(mk("pu_c9",    2'b01, 2'b01, 2'b11, 2'b00, 1, S_ON, S_OFF));
    vecs_a.push_back(mk("on_hold",  2'b01, 2'b01, 2'b11, 2'b00, 5, S_ON, S_OFF));
    vecs_a.push_back(mk("pd_c1",    2'b00, 2'b00, 2'b10, 2'b00, 1, S_IWAIT, S_OFF));
    vecs_a.push_back(mk("pd_c3",    2'b00, 2'b00, 2'b10, 2'b00, 2, S_IWAIT, S_OFF));
    vecs_a.push_back(mk("pd_c4",    2'b00, 2'b00, 2'b11, 2'b00, 1, S_RASS, S_OFF));
    vecs_a.push_back(mk("pd_c7",    2'b00, 2'b00, 2'b11, 2'b00, 3, S_RASS, S_OFF));
    vecs_a.push_back(mk("pd_c8",    2'b00, 2'b00, 2'b11, 2'b00, 1, S_OFF, S_OFF));
    vecs_a.push_back(mk("pu2_on",   2'b01, 2'b01, 2'b11, 2'b00, 12, S_ON, S_OFF));
    vecs_a.push_back(mk("to_c1",    2'b00, 2'b00, 2'b10, 2'b00, 1, S_IWAIT, S_OFF));
    vecs_a.push_back(mk("to_c7",    2'b00, 2'b00, 2'b10, 2'b00, 6, S_IWAIT, S_OFF));
    vecs_a.push_back(mk("to_c8",    2'b00, 2'b00, 2'b10, 2'b00, 1, S_IWAIT | S_ERR, S_OFF));
    vecs_a.push_back(mk("to_hold",  2'b00, 2'b00, 2'b10, 2'b00, 5, S_IWAIT | S_ERR, S_OFF));
    vecs_a.push_back(mk("ab_deiso", 2'b01, 2'b00, 2'b10, 2'b00, 1, S_DEISO | S_ERR, S_OFF));
    vecs_a.push_back(mk("ab_on",    2'b01, 2'b00, 2'b10, 2'b00, 1, S_ON | S_ERR, S_OFF));
    vecs_a.push_back(mk("clr_err",  2'b01, 2'b00, 2'b10, 2'b01, 1, S_ON, S_OFF));
    vecs_a.push_back(mk("x_c1",     2'b10, 2'b11, 2'b10, 2'b00, 1, S_IWAIT, S_CKON));
    vecs_a.push_back(mk("x_c3",     2'b10, 2'b11, 2'b10, 2'b00, 2, S_RASS, S_CKON));
    vecs_a.push_back(mk("x_c5",     2'b10, 2'b11, 2'b10, 2'b00, 2, S_RASS, S_RREL));
    vecs_a.push_back(mk("x_c7",     2'b10, 2'b11, 2'b10, 2'b00, 2, S_OFF, S_DEISO));
    vecs_a.push_back(mk("x_c9",     2'b10, 2'b11, 2'b10, 2'b00, 2, S_OFF, S_ON));
    vecs_a.push_back(mk("mr_c5",    2'b11, 2'b11, 2'b10, 2'b00, 5, S_RREL, S_ON));
    vecs_b.push_back(mk("post_rst", 2'b00, 2'b00, 2'b11, 2'b00, 4, S_OFF, S_OFF));
    vecs_b.push_back(mk("pu3_on",   2'b01, 2'b01, 2'b11, 2'b00, 12, S_ON, S_OFF));
    vecs_b.push_back(mk("tp_c7",    2'b00, 2'b00, 2'b10, 2'b00, 7, S_IWAIT, S_OFF));
    vecs_b.push_back(mk("tp_setpri", 2'b00, 2'b00, 2'b10, 2'b01, 1, S_IWAIT | S_ERR, S_OFF));
    vecs_b.push_back(mk("tp_clr",   2'b00, 2'b00, 2'b10, 2'b01, 1, S_IWAIT, S_OFF));
    vecs_b.push_back(mk("tp_stay",  2'b00, 2'b00, 2'b10, 2'b00, 4, S_IWAIT, S_OFF));

    rst_n = 1'b0; req = '0; iso_in = '1; clr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    sb.push_back(mk("in_reset", 2'b00, 2'b00, 2'b11, 2'b00, 0, S_OFF, S_OFF));
    check_sb();
    rst_n = 1'b1;
    foreach (vecs_a[i]) run_vec(vecs_a[i]);
    // Asynchronous reset mid power-up: outputs must drop before the next clock edge.
    rst_n = 1'b0;
    #1;
    sb.push_back(mk("async_rst", 2'b11, 2'b11, 2'b10, 2'b00, 0, S_OFF, S_OFF));
    check_sb();
    req = '0; iso_in = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs_b[i]) run_vec(vecs_b[i]);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
